// File: rtl/ccl_pkg.sv
// Shared types for the loop-control dispatch block: op encoding, FSM states, fault codes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ccl_pkg;

  // Depth of the external loop-counter stack unit.
  localparam int CCL_DEPTH = 16;

  typedef enum logic [1:0] {
    OP_FLUSH   = 2'b00,
    OP_BREAK   = 2'b01,
    OP_LOOP    = 2'b10,
    OP_ILLEGAL = 2'b11
  } ccl_op_e;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_OUT   = 3'd4
  } ccl_state_e;

  typedef enum logic [1:0] {
    FC_NONE       = 2'b00,
    FC_ILLEGAL    = 2'b01,
    FC_STACK_ERR  = 2'b10,
    FC_STACK_FULL = 2'b11
  } ccl_fault_e;

endpackage

// File: rtl/ccl_redirect_reg.sv
// Fetch-redirect output register: holds redir_valid/redir_target until fetch accepts.
// Latency: load visible on outputs the cycle after the load pulse.
// Backpressure: redir_target is frozen while redir_valid && !redir_ready.
// Ports: clock/reset (async active-low), load + load_target from the dispatcher,
//        redir_ready from fetch, redir_valid/redir_target to fetch.
module ccl_redirect_reg (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] load_target,
  input  logic        redir_ready,
  output logic        redir_valid,
  output logic [31:0] redir_target
);

  logic        valid_q, valid_d;
  logic [31:0] target_q, target_d;

  always_comb begin
    valid_d  = valid_q;
    target_d = target_q;
    if (valid_q && redir_ready) begin
      valid_d = 1'b0;
    end
    // The dispatcher only loads from WAIT, never while a redirect is pending.
    if (load) begin
      valid_d  = 1'b1;
      target_d = load_target;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q  <= 1'b0;
      target_q <= 32'h0;
    end else begin
      valid_q  <= valid_d;
      target_q <= target_d;
    end
  end

  assign redir_valid  = valid_q;
  assign redir_target = target_q;

endmodule

// File: rtl/ccl_dispatch.sv
// Loop-control dispatcher: turns decoded FLUSH/BREAK/LOOP ops into loop-counter stack
// commands and fetch redirects. Latency: accept N -> ccl_command N+1 -> redir_valid N+3.
// Backpressure: one op in flight; in_ready only in IDLE, OUT holds until redir_ready.
// Ports: clock, reset (async active-low); in_* decoded-op handshake; ccl_* command to and
//        registered response from the stack unit; redir_* fetch redirect; fault/fault_code.
module ccl_dispatch
  import ccl_pkg::*;
#(
  parameter int unsigned PC_STEP = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_op,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_count,
  input  logic [31:0] in_offset,
  output logic [1:0]  ccl_command,
  output logic [31:0] ccl_address,
  output logic [31:0] ccl_counter,
  output logic [31:0] ccl_inTarget,
  output logic        ccl_reset,
  input  logic [31:0] ccl_outTarget,
  input  logic        ccl_valid,
  input  logic        ccl_full,
  input  logic        ccl_error,
  output logic        redir_valid,
  output logic [31:0] redir_target,
  input  logic        redir_ready,
  output logic        fault,
  output logic [1:0]  fault_code
);

  localparam logic [31:0] STEP = 32'(PC_STEP);

  ccl_state_e  state_q, state_d;
  ccl_op_e     cmd_q, cmd_d;
  ccl_op_e     op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] tgt_q, tgt_d;
  logic [31:0] pc_q, pc_d;
  logic        fault_q, fault_d;
  ccl_fault_e  fault_code_q, fault_code_d;
  logic        flush_q, flush_d;

  logic        redir_load;
  logic [31:0] redir_load_tgt;
  ccl_op_e     in_op_e;

  // A stack-unit failure reports full vs. generic error only; ccl_error carries no extra
  // information once ccl_valid is low, so it is not decoded separately.
  logic unused_ccl_error;
  assign unused_ccl_error = ccl_error;

  assign in_op_e = ccl_op_e'(in_op);

  always_comb begin
    state_d        = state_q;
    cmd_d          = OP_FLUSH;
    op_d           = op_q;
    addr_d         = addr_q;
    cnt_d          = cnt_q;
    tgt_d          = tgt_q;
    pc_d           = pc_q;
    fault_d        = fault_q;
    fault_code_d   = fault_code_q;
    flush_d        = 1'b0;
    redir_load     = 1'b0;
    redir_load_tgt = pc_q + STEP;

    case (state_q)
      ST_INIT: begin
        state_d = ST_IDLE;
      end

      ST_IDLE: begin
        if (in_valid) begin
          case (in_op_e)
            OP_FLUSH: begin
              flush_d      = 1'b1;
              fault_d      = 1'b0;
              fault_code_d = FC_NONE;
            end
            OP_BREAK, OP_LOOP: begin
              if (in_op_e == OP_LOOP && in_count == 32'h0) begin
                fault_d      = 1'b1;
                fault_code_d = FC_ILLEGAL;
              end else begin
                op_d    = in_op_e;
                pc_d    = in_pc;
                cmd_d   = in_op_e;
                addr_d  = in_pc;
                cnt_d   = in_count;
                // Plain 32-bit adds: targets wrap modulo 2^32 by design.
                tgt_d   = (in_op_e == OP_LOOP) ? (in_pc + in_offset) : (in_pc + STEP);
                state_d = ST_ISSUE;
              end
            end
            default: begin
              fault_d      = 1'b1;
              fault_code_d = FC_ILLEGAL;
            end
          endcase
        end
      end

      // cmd_q is only non-FLUSH for the single cycle spent here.
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end

      // Stack response is registered, so it is valid exactly one cycle after ISSUE.
      ST_WAIT: begin
        if (op_q == OP_BREAK) begin
          redir_load     = 1'b1;
          redir_load_tgt = pc_q + STEP;
          state_d        = ST_OUT;
        end else if (ccl_valid) begin
          redir_load     = 1'b1;
          redir_load_tgt = ccl_outTarget;
          state_d        = ST_OUT;
        end else begin
          fault_d      = 1'b1;
          fault_code_d = ccl_full ? FC_STACK_FULL : FC_STACK_ERR;
          state_d      = ST_IDLE;
        end
      end

      ST_OUT: begin
        if (redir_valid && redir_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_INIT;
      cmd_q        <= OP_FLUSH;
      op_q         <= OP_FLUSH;
      addr_q       <= 32'h0;
      cnt_q        <= 32'h0;
      tgt_q        <= 32'h0;
      pc_q         <= 32'h0;
      fault_q      <= 1'b0;
      fault_code_q <= FC_NONE;
      flush_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
      tgt_q        <= tgt_d;
      pc_q         <= pc_d;
      fault_q      <= fault_d;
      fault_code_q <= fault_code_d;
      flush_q      <= flush_d;
    end
  end

  ccl_redirect_reg u_redirect (
    .clock       (clock),
    .reset       (reset),
    .load        (redir_load),
    .load_target (redir_load_tgt),
    .redir_ready (redir_ready),
    .redir_valid (redir_valid),
    .redir_target(redir_target)
  );

  // INIT's clear is gated by reset so the stack unit sees no clear while reset is held;
  // it is sampled by the stack unit on the first edge after release.
  assign ccl_reset    = flush_q | ((state_q == ST_INIT) & reset);
  assign in_ready     = (state_q == ST_IDLE);
  assign ccl_command  = cmd_q;
  assign ccl_address  = addr_q;
  assign ccl_counter  = cnt_q;
  assign ccl_inTarget = tgt_q;
  assign fault        = fault_q;
  assign fault_code   = fault_code_q;

endmodule

// File: tb/tb_ccl_dispatch.sv
// Directed bench for ccl_dispatch with hand-computed expected values.
// Latency: n/a. Backpressure: exercised via redir_ready held low in OUT.
module tb_ccl_dispatch;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_op = 2'b00;
  logic [31:0] in_pc = 32'h0;
  logic [31:0] in_count = 32'h0;
  logic [31:0] in_offset = 32'h0;
  logic [1:0]  ccl_command;
  logic [31:0] ccl_address;
  logic [31:0] ccl_counter;
  logic [31:0] ccl_inTarget;
  logic        ccl_reset;
  logic [31:0] ccl_outTarget = 32'h0;
  logic        ccl_valid = 1'b0;
  logic        ccl_full = 1'b0;
  logic        ccl_error = 1'b0;
  logic        redir_valid;
  logic [31:0] redir_target;
  logic        redir_ready = 1'b1;
  logic        fault;
  logic [1:0]  fault_code;

  int checks = 0;
  int errors = 0;

  ccl_dispatch #(.PC_STEP(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_op        (in_op),
    .in_pc        (in_pc),
    .in_count     (in_count),
    .in_offset    (in_offset),
    .ccl_command  (ccl_command),
    .ccl_address  (ccl_address),
    .ccl_counter  (ccl_counter),
    .ccl_inTarget (ccl_inTarget),
    .ccl_reset    (ccl_reset),
    .ccl_outTarget(ccl_outTarget),
    .ccl_valid    (ccl_valid),
    .ccl_full     (ccl_full),
    .ccl_error    (ccl_error),
    .redir_valid  (redir_valid),
    .redir_target (redir_target),
    .redir_ready  (redir_ready),
    .fault        (fault),
    .fault_code   (fault_code)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [31:0] pc,
                      input logic [31:0] cnt, input logic [31:0] off);
    in_valid  = 1'b1;
    in_op     = op;
    in_pc     = pc;
    in_count  = cnt;
    in_offset = off;
    step();
    in_valid  = 1'b0;
  endtask

  initial begin
    // ---- reset state ----
    #1 reset = 1'b0;
    #2;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_redir_valid", redir_valid, 0);
    chk("rst_redir_target", redir_target, 0);
    chk("rst_command", ccl_command, 0);
    chk("rst_address", ccl_address, 0);
    chk("rst_counter", ccl_counter, 0);
    chk("rst_intarget", ccl_inTarget, 0);
    chk("rst_fault", fault, 0);
    chk("rst_fault_code", fault_code, 0);
    chk("rst_ccl_reset", ccl_reset, 0);
    step();
    step();
    reset = 1'b1;
    #1;
    chk("init_ccl_reset", ccl_reset, 1);
    chk("init_in_ready", in_ready, 0);
    chk("init_command", ccl_command, 0);
    step();
    chk("idle_ccl_reset", ccl_reset, 0);
    chk("idle_in_ready", in_ready, 1);

    // ---- LOOP pc=0x100 count=3 offset=-0x20, stack returns 0xE0 ----
    ccl_valid = 1'b1; ccl_outTarget = 32'h0000_00E0;
    send(2'b10, 32'h100, 32'd3, 32'hFFFF_FFE0);
    chk("loop_cmd", ccl_command, 2);
    chk("loop_addr", ccl_address, 32'h100);
    chk("loop_cnt", ccl_counter, 3);
    chk("loop_tgt", ccl_inTarget, 32'hE0);
    chk("loop_busy", in_ready, 0);
    step();
    chk("loop_wait_cmd", ccl_command, 0);
    chk("loop_wait_tgt_hold", ccl_inTarget, 32'hE0);
    chk("loop_wait_addr_hold", ccl_address, 32'h100);
    chk("loop_wait_rv", redir_valid, 0);
    step();
    chk("loop_out_rv", redir_valid, 1);
    chk("loop_out_rt", redir_target, 32'hE0);
    chk("loop_out_busy", in_ready, 0);
    step();
    chk("loop_done_rv", redir_valid, 0);
    chk("loop_done_ready", in_ready, 1);

    // ---- BREAK pc=0x200, ccl_valid=0, fetch stalls for 5 cycles ----
    ccl_valid = 1'b0; ccl_outTarget = 32'hDEAD_BEEF;
    redir_ready = 1'b0;
    send(2'b01, 32'h200, 32'd0, 32'h0);
    chk("brk_cmd", ccl_command, 1);
    chk("brk_tgt", ccl_inTarget, 32'h204);
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      chk("brk_stall_rv", redir_valid, 1);
      chk("brk_stall_rt", redir_target, 32'h204);
      chk("brk_stall_busy", in_ready, 0);
      chk("brk_stall_cmd", ccl_command, 0);
      if (i < 4) step();
    end
    redir_ready = 1'b1;
    step();
    chk("brk_done_rv", redir_valid, 0);
    chk("brk_done_ready", in_ready, 1);

    // ---- LOOP with stack full and error both set -> code 11, then FLUSH ----
    ccl_full = 1'b1; ccl_error = 1'b1;
    send(2'b10, 32'h300, 32'd1, 32'h8);
    chk("full_cmd", ccl_command, 2);
    chk("full_tgt", ccl_inTarget, 32'h308);
    step();
    step();
    chk("full_fault", fault, 1);
    chk("full_code", fault_code, 3);
    chk("full_rv", redir_valid, 0);
    chk("full_ready", in_ready, 1);
    send(2'b00, 32'h0, 32'h0, 32'h0);
    chk("flush_pulse", ccl_reset, 1);
    chk("flush_cmd", ccl_command, 0);
    chk("flush_fault", fault, 0);
    chk("flush_code", fault_code, 0);
    chk("flush_ready", in_ready, 1);
    step();
    chk("flush_pulse_end", ccl_reset, 0);
    chk("flush_rv", redir_valid, 0);

    // ---- LOOP with wrapping target, stack error only -> code 10 ----
    ccl_full = 1'b0; ccl_error = 1'b1;
    send(2'b10, 32'hFFFF_FFF0, 32'd7, 32'h20);
    chk("wrap_tgt", ccl_inTarget, 32'h10);
    step();
    step();
    chk("err_fault", fault, 1);
    chk("err_code", fault_code, 2);
    chk("err_rv", redir_valid, 0);
    ccl_error = 1'b0;

    // ---- zero-count LOOP then illegal op -> code 01, nothing issued ----
    send(2'b10, 32'h400, 32'd0, 32'h10);
    chk("zc_cmd", ccl_command, 0);
    chk("zc_fault", fault, 1);
    chk("zc_code", fault_code, 1);
    chk("zc_ready", in_ready, 1);
    step();
    chk("zc_cmd2", ccl_command, 0);
    send(2'b11, 32'h500, 32'd2, 32'h10);
    chk("ill_cmd", ccl_command, 0);
    chk("ill_code", fault_code, 1);
    chk("ill_ready", in_ready, 1);

    // ---- reset asserted mid-WAIT ----
    ccl_valid = 1'b1; ccl_outTarget = 32'h600;
    send(2'b10, 32'h640, 32'd2, 32'hFFFF_FFC0);
    step();
    #1 reset = 1'b0;
    #1;
    chk("mid_rst_cmd", ccl_command, 0);
    chk("mid_rst_addr", ccl_address, 0);
    chk("mid_rst_cnt", ccl_counter, 0);
    chk("mid_rst_tgt", ccl_inTarget, 0);
    chk("mid_rst_rv", redir_valid, 0);
    chk("mid_rst_rt", redir_target, 0);
    chk("mid_rst_fault", fault, 0);
    chk("mid_rst_code", fault_code, 0);
    chk("mid_rst_ready", in_ready, 0);
    chk("mid_rst_cclrst", ccl_reset, 0);
    step();
    chk("mid_rst_hold_rv", redir_valid, 0);
    reset = 1'b1;
    #1;
    chk("rel_cclrst", ccl_reset, 1);
    chk("rel_ready", in_ready, 0);
    step();
    chk("rel_cclrst_end", ccl_reset, 0);
    chk("rel_ready_up", in_ready, 1);
    step();
    step();
    chk("rel_no_redir", redir_valid, 0);
    chk("rel_no_cmd", ccl_command, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
